// File: rtl/rst_rcv_pkg.sv
// Shared definitions for the board reset-pin receiver: state encoding,
// default parameter values and the event-counter saturation ceiling.
package rst_rcv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_STRETCH = 2'd3
    } state_t;

    localparam int DEF_MIN_LOW = 16;
    localparam int DEF_STRETCH = 8;
    localparam int DEF_CNT_W   = 8;

    // Saturation ceiling of an event counter at the default width.
    localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = '1;

endpackage

// File: rtl/rst_sync2.sv
// Generic two-flop synchroniser for a single asynchronous pin. The reset
// value is a parameter so the same cell serves pins of either polarity.
module rst_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; the first flop may go metastable, the second settles it.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so both stages sample the old values; blocking would merge them into one flop.
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rst_rcv.sv
// Board reset-pin receiver: synchronises the active-low pin, rejects short
// low pulses, drives a stretched system reset and counts events for debug.
module rst_rcv
    import rst_rcv_pkg::*;
#(
    parameter int MIN_LOW = DEF_MIN_LOW,
    parameter int STRETCH = DEF_STRETCH,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             P_MCLK,
    input  logic             P_RST,
    input  logic             I_RST_X,
    output logic             O_SYS_RST,
    output logic             O_RST_DONE,
    output logic             O_GLITCH,
    output logic [CNT_W-1:0] O_RST_CNT,
    output logic [CNT_W-1:0] O_GLT_CNT,
    output logic [1:0]       O_STATE
);

    localparam int CW = $clog2(MIN_LOW > STRETCH ? MIN_LOW : STRETCH);
    localparam logic [CW-1:0]    QUAL_LAST = CW'(MIN_LOW - 1);
    localparam logic [CW-1:0]    STR_LAST  = CW'(STRETCH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           done_nx, glitch_nx;
    logic           s;

    // Pin resets to 0 so the core starts out treating the pin as asserted.
    rst_sync2 #(.RST_VAL(1'b0)) u_sync (
        .clk (P_MCLK),
        .rst (P_RST),
        .d   (I_RST_X),
        .q   (s)
    );

    // Next-state logic: qualify low runs, hold while low, stretch on release.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        state_nx  = state;
        cnt_nx    = cnt;
        done_nx   = 1'b0;
        glitch_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!s) begin
                    state_nx = ST_QUAL;
                    cnt_nx   = CW'(1);
                end
            end
            ST_QUAL: begin
                if (s) begin
                    state_nx  = ST_IDLE;
                    glitch_nx = 1'b1;
                end else if (cnt == QUAL_LAST) begin
                    state_nx = ST_ASSERT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_ASSERT: begin
                if (s) begin
                    state_nx = ST_STRETCH;
                    cnt_nx   = '0;
                end
            end
            ST_STRETCH: begin
                if (!s) begin
                    state_nx = ST_ASSERT;
                end else if (cnt == STR_LAST) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = ST_ASSERT;
        endcase
    end

    // State and counter register; block reset re-runs the power-on sequence.
    always_ff @(posedge P_MCLK) begin
        if (P_RST) begin
            state <= ST_ASSERT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Registered outputs decoded from the next state, plus saturating event counters.
    always_ff @(posedge P_MCLK) begin
        if (P_RST) begin
            O_SYS_RST  <= 1'b1;
            O_RST_DONE <= 1'b0;
            O_GLITCH   <= 1'b0;
            O_RST_CNT  <= '0;
            O_GLT_CNT  <= '0;
        end else begin
            O_SYS_RST  <= (state_nx == ST_ASSERT) || (state_nx == ST_STRETCH);
            O_RST_DONE <= done_nx;
            O_GLITCH   <= glitch_nx;
            if (done_nx && (O_RST_CNT != CNT_MAX)) begin
                O_RST_CNT <= O_RST_CNT + 1'b1;
            end
            if (glitch_nx && (O_GLT_CNT != CNT_MAX)) begin
                O_GLT_CNT <= O_GLT_CNT + 1'b1;
            end
        end
    end

    assign O_STATE = state;

endmodule

// File: tb/tb_rst_rcv.sv
// Self-checking bench for rst_rcv: run-length reference model checked every
// cycle, a table of pulse lengths, and hand-written multi-cycle sequences.
module tb_rst_rcv;

    localparam int MIN_LOW = 16;
    localparam int STRETCH = 8;

    logic       clk;
    logic       rst;
    logic       pin;

    logic       sys_rst, done, glitch;
    logic [7:0] rst_cnt, glt_cnt;
    logic [1:0] state;

    logic       s_sys_rst, s_done, s_glitch;
    logic [1:0] s_rst_cnt, s_glt_cnt;
    logic [1:0] s_state;

    int checks = 0;
    int errors = 0;

    // Reference model: pin history plus run lengths of low/high synchronised samples.
    bit sh1, sh2;
    bit m_asserted;
    int low_run, high_run;
    int m_rst_cnt, m_glt_cnt;
    bit m_done, m_glitch;

    rst_rcv u_dut (
        .P_MCLK     (clk),
        .P_RST      (rst),
        .I_RST_X    (pin),
        .O_SYS_RST  (sys_rst),
        .O_RST_DONE (done),
        .O_GLITCH   (glitch),
        .O_RST_CNT  (rst_cnt),
        .O_GLT_CNT  (glt_cnt),
        .O_STATE    (state)
    );

    rst_rcv #(.CNT_W(2)) u_sat (
        .P_MCLK     (clk),
        .P_RST      (rst),
        .I_RST_X    (pin),
        .O_SYS_RST  (s_sys_rst),
        .O_RST_DONE (s_done),
        .O_GLITCH   (s_glitch),
        .O_RST_CNT  (s_rst_cnt),
        .O_GLT_CNT  (s_glt_cnt),
        .O_STATE    (s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // One clock edge of the reference model using the inputs present at that edge.
    task automatic model_step();
        bit s_now;
        m_done   = 1'b0;
        m_glitch = 1'b0;
        if (rst) begin
            sh1 = 1'b0; sh2 = 1'b0;
            m_asserted = 1'b1;
            low_run = 0; high_run = 0;
            m_rst_cnt = 0; m_glt_cnt = 0;
            return;
        end
        s_now = sh2;
        sh2   = sh1;
        sh1   = pin;
        if (!m_asserted) begin
            if (!s_now) begin
                low_run++;
                if (low_run == MIN_LOW) begin
                    m_asserted = 1'b1;
                    low_run = 0;
                    high_run = 0;
                end
            end else if (low_run > 0) begin
                m_glitch = 1'b1;
                m_glt_cnt++;
                low_run = 0;
            end
        end else begin
            if (!s_now) begin
                high_run = 0;
            end else begin
                high_run++;
                if (high_run == STRETCH + 1) begin
                    m_asserted = 1'b0;
                    high_run = 0;
                    m_done = 1'b1;
                    m_rst_cnt++;
                end
            end
        end
    endtask

    task automatic compare_all();
        int exp_state;
        if (m_asserted) exp_state = (high_run > 0) ? 3 : 2;
        else            exp_state = (low_run > 0) ? 1 : 0;
        check("sys_rst", sys_rst, m_asserted);
        check("rst_done", done, m_done);
        check("glitch", glitch, m_glitch);
        check("rst_cnt", rst_cnt, sat(m_rst_cnt, 8));
        check("glt_cnt", glt_cnt, sat(m_glt_cnt, 8));
        check("state", state, exp_state);
        check("sat_sys_rst", s_sys_rst, m_asserted);
        check("sat_done", s_done, m_done);
        check("sat_glitch", s_glitch, m_glitch);
        check("sat_rst_cnt", s_rst_cnt, sat(m_rst_cnt, 2));
        check("sat_glt_cnt", s_glt_cnt, sat(m_glt_cnt, 2));
        check("sat_state", s_state, exp_state);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_high(input int n);
        pin = 1'b1;
        for (int t = 0; t < n; t++) tick();
    endtask

    // Low phase starting from IDLE: system reset rises on the (MIN_LOW+2)th low tick.
    task automatic board_low(input int n);
        pin = 1'b0;
        for (int t = 1; t <= n; t++) begin
            tick();
            check("board_low_sys_rst", sys_rst, t >= MIN_LOW + 2);
        end
    endtask

    // High phase starting from ASSERT: reset falls, with DONE, on tick STRETCH+3.
    task automatic board_high(input int n);
        pin = 1'b1;
        for (int t = 1; t <= n; t++) begin
            tick();
            check("board_high_sys_rst", sys_rst, t < STRETCH + 3);
            check("board_high_done", done, t == STRETCH + 3);
        end
    endtask

    typedef struct {
        int low_len;
        int high_len;
        int exp_rst_inc;
        int exp_glt_inc;
    } vec_t;

    vec_t vecs[8];
    int   exp_rst_total;
    int   exp_glt_total;
    int   glitch_pulses;
    int   done_pulses;
    bit   saw_sys_rst;
    bit   held;

    initial begin
        vecs[0] = '{10, 20, 0, 1};
        vecs[1] = '{15, 20, 0, 1};
        vecs[2] = '{16, 20, 1, 0};
        vecs[3] = '{1,  20, 0, 1};
        vecs[4] = '{17, 20, 1, 0};
        vecs[5] = '{2,  20, 0, 1};
        vecs[6] = '{14, 20, 0, 1};
        vecs[7] = '{40, 25, 1, 0};

        // Power-on: reset held with the pin high.
        rst = 1'b1;
        pin = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        check("reset_sys_rst", sys_rst, 1);
        check("reset_done", done, 0);
        check("reset_glitch", glitch, 0);
        check("reset_rst_cnt", rst_cnt, 0);
        check("reset_glt_cnt", glt_cnt, 0);
        check("reset_state", state, 2);

        rst = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            check("por_sys_rst", sys_rst, t <= STRETCH + 2);
            check("por_done", done, t == STRETCH + 3);
        end
        check("por_rst_cnt", rst_cnt, 1);

        // Board sequence: low 28, high 14, low 28, then high.
        idle_high(3);
        board_low(28);
        board_high(14);
        board_low(28);
        board_high(20);
        check("board_rst_cnt", rst_cnt, 3);
        check("board_glt_cnt", glt_cnt, 0);

        // Table of pulse lengths around the acceptance boundary.
        exp_rst_total = 3;
        exp_glt_total = 0;
        foreach (vecs[i]) begin
            glitch_pulses = 0;
            saw_sys_rst = 1'b0;
            pin = 1'b0;
            for (int t = 0; t < vecs[i].low_len; t++) begin
                tick();
                if (glitch) glitch_pulses++;
                if (sys_rst) saw_sys_rst = 1'b1;
            end
            pin = 1'b1;
            for (int t = 0; t < vecs[i].high_len; t++) begin
                tick();
                if (glitch) glitch_pulses++;
                if (sys_rst) saw_sys_rst = 1'b1;
            end
            exp_rst_total += vecs[i].exp_rst_inc;
            exp_glt_total += vecs[i].exp_glt_inc;
            check("vec_glitch_pulses", glitch_pulses, vecs[i].exp_glt_inc);
            check("vec_sys_rst_seen", saw_sys_rst, vecs[i].exp_rst_inc);
            check("vec_rst_cnt", rst_cnt, exp_rst_total);
            check("vec_glt_cnt", glt_cnt, exp_glt_total);
        end
        check("sat_glt_stays_3", s_glt_cnt, 3);
        check("sat_rst_stays_3", s_rst_cnt, 3);
        check("nosat_glt_cnt", glt_cnt, 5);

        // Stretch re-entry: pin drops again partway through the stretch.
        board_low(20);
        done_pulses = 0;
        held = 1'b1;
        pin = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (!sys_rst) held = 1'b0;
            if (done) done_pulses++;
        end
        check("reentry_in_stretch", state, 3);
        pin = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (!sys_rst) held = 1'b0;
            if (done) done_pulses++;
        end
        check("reentry_back_to_assert", state, 2);
        check("reentry_held", held, 1);
        board_high(20);
        check("reentry_done_before_final", done_pulses, 0);
        check("reentry_rst_cnt", rst_cnt, exp_rst_total + 1);

        // Block reset in the middle of qualification.
        board_low(9);
        check("midqual_state", state, 1);
        rst = 1'b1;
        pin = 1'b1;
        tick();
        check("midqual_sys_rst", sys_rst, 1);
        check("midqual_state_after", state, 2);
        check("midqual_rst_cnt", rst_cnt, 0);
        check("midqual_glt_cnt", glt_cnt, 0);
        rst = 1'b0;
        idle_high(15);
        check("midqual_por_cnt", rst_cnt, 1);

        // Block reset in the middle of the stretch.
        board_low(20);
        idle_high(5);
        check("midstr_state", state, 3);
        rst = 1'b1;
        tick();
        check("midstr_sys_rst", sys_rst, 1);
        check("midstr_state_after", state, 2);
        check("midstr_rst_cnt", rst_cnt, 0);
        check("midstr_sat_rst_cnt", s_rst_cnt, 0);
        rst = 1'b0;
        idle_high(15);

        // Random low/high runs with occasional block resets.
        for (int b = 0; b < 200; b++) begin
            int lo;
            int hi;
            lo = int'($urandom_range(24, 1));
            hi = int'($urandom_range(20, 1));
            rst = ($urandom_range(49, 0) == 0);
            pin = 1'b0;
            for (int t = 0; t < lo; t++) begin
                tick();
                rst = 1'b0;
            end
            pin = 1'b1;
            for (int t = 0; t < hi; t++) tick();
        end
        idle_high(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
